// File: rtl/ps2_kbd_controller.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events, buffers them in a FWFT FIFO.
// Define PS2_KBD_TIMEOUT_EN to abandon a pending prefix after TIMEOUT_CYC idle cycles.
module ps2_kbd_controller #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 32000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_enable,
    output logic [9:0] ev_data,
    output logic       ev_empty,
    input  logic       ev_rd,
    output logic [6:0] ev_count,
    output logic [7:0] status_code,
    output logic       status_strobe,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("ps2_kbd_controller: illegal DEPTH or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0} state_t;

    state_t        state_q, state_d;
    logic          rx_valid_q;
    logic          rx_enable_q;
    logic [7:0]    status_code_q, status_code_d;
    logic          status_strobe_q, status_strobe_d;
    logic          overflow_q, overflow_d;
    logic [6:0]    count_q, count_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [9:0]    mem_q [DEPTH];

    logic       accept, full, empty, pop, push_req, push_ok, ovf_set, tmo_hit;
    logic [9:0] push_ev;

    assign accept = enable & rx_valid & ~rx_valid_q;
    assign full   = (count_q == 7'(DEPTH));
    assign empty  = (count_q == 7'd0);
    assign pop    = ev_rd & ~empty;

    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFC, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_status = 1'b1;
            default:                                         is_status = 1'b0;
        endcase
    endfunction

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || accept || !enable || state_q == IDLE) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        push_req        = 1'b0;
        push_ev         = '0;
        status_code_d   = status_code_q;
        status_strobe_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = PRE_E0;
                    end else if (rx_data == 8'hF0) begin
                        state_d = PRE_F0;
                    end else if (is_status(rx_data)) begin
                        status_code_d   = rx_data;
                        status_strobe_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_ev  = {2'b00, rx_data};
                    end
                end
                PRE_E0: begin
                    if (rx_data == 8'hF0) begin
                        state_d = PRE_E0F0;
                    end else if (rx_data != 8'hE0) begin
                        state_d  = IDLE;
                        push_req = 1'b1;
                        push_ev  = {2'b10, rx_data};
                    end
                end
                PRE_F0: begin
                    state_d  = IDLE;
                    push_req = (rx_data != 8'hE0) && (rx_data != 8'hF0);
                    push_ev  = {2'b01, rx_data};
                end
                default: begin
                    state_d  = IDLE;
                    push_req = (rx_data != 8'hE0) && (rx_data != 8'hF0);
                    push_ev  = {2'b11, rx_data};
                end
            endcase
        end else if (tmo_hit) begin
            state_d = IDLE;
        end
        // An event that cannot be stored abandons whatever sequence was in flight.
        if (push_req && full && !pop) begin
            state_d = IDLE;
        end
    end

    assign push_ok    = push_req & (~full | pop);
    assign ovf_set    = push_req & full & ~pop;
    assign overflow_d = (overflow_q & ~clr_ovf) | ovf_set;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rx_valid_q      <= 1'b0;
            rx_enable_q     <= 1'b0;
            status_code_q   <= 8'h00;
            status_strobe_q <= 1'b0;
            overflow_q      <= 1'b0;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
        end else begin
            state_q         <= state_d;
            rx_valid_q      <= rx_valid;
            rx_enable_q     <= enable & ~full;
            status_code_q   <= status_code_d;
            status_strobe_q <= status_strobe_d;
            overflow_q      <= overflow_d;
            count_q         <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is never reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_ev;
    end

    assign rx_enable     = rx_enable_q;
    assign ev_empty      = empty;
    assign ev_data       = empty ? 10'h000 : mem_q[rd_ptr_q];
    assign ev_count      = count_q;
    assign status_code   = status_code_q;
    assign status_strobe = status_strobe_q;
    assign overflow      = overflow_q;

endmodule
